// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM loader.
//   state_t      - loader FSM states (IDLE / ARM / WRITE)
//   page_bits()  - width of the SDRAM page field, ADDR_W - PAGE_W
//   DEF_PAGE_MAP - default slot -> SDRAM page table, slot 0 in the LSBs
//   IOCTL_ADDR_W - width of the hps_io download address
package rom_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  function automatic int page_bits(input int addr_w, input int page_w);
    return addr_w - page_w;
  endfunction

  localparam int IOCTL_ADDR_W = 25;

  localparam logic [35:0] DEF_PAGE_MAP = {9'h107, 9'h100, 9'h000, 9'h000};

endpackage

// File: rtl/rom_page_match.sv
// Page lookup for probe_rom: hit is high when some loaded slot maps to the
// probed SDRAM page. Duplicate mappings simply OR together.
//   loaded     - per-slot loaded flags
//   page_map   - SLOTS x PW page table, slot 0 in the LSBs
//   probe_page - page field of the probed address
//   hit        - combinational match result
module rom_page_match
  import rom_loader_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int PW    = 9
) (
  input  logic [SLOTS-1:0]    loaded,
  input  logic [SLOTS*PW-1:0] page_map,
  input  logic [PW-1:0]       probe_page,
  output logic                hit
);

  logic [SLOTS-1:0] slot_hit;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign slot_hit[i] = loaded[i] && (page_map[i*PW +: PW] == probe_page);
  end

  assign hit = |slot_hit;

endmodule

// File: rtl/rom_loader.sv
// ROM loader: takes the hps_io byte download stream, maps each byte's
// 2^PAGE_W-byte slot onto an SDRAM page and writes it through a single
// SDRAM write port paced by the ce_ref reference-slot strobe.
//   clk_sys, reset          - clock, async active-high reset
//   ce_ref                  - SDRAM reference-slot strobe
//   ioctl_*                 - hps_io download stream; ioctl_wait stalls it
//   ram_we/ram_addr/ram_din - SDRAM write port
//   rom_download            - download of ROM_INDEX in progress (comb)
//   loaded/done/overflow    - per-slot loaded, end-of-download pulse, dropped bytes
//   probe_addr/probe_rom    - address lies in a mapped, loaded page (comb)
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W    = 23,
  parameter int PAGE_W    = 14,
  parameter int SLOTS     = 4,
  parameter logic [7:0] ROM_INDEX = 8'd0,
  parameter logic [SLOTS*page_bits(ADDR_W, PAGE_W)-1:0] PAGE_MAP = DEF_PAGE_MAP
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ce_ref,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [7:0]              ram_din,
  output logic                    rom_download,
  output logic [SLOTS-1:0]        loaded,
  output logic                    done,
  output logic                    overflow,
  input  logic [ADDR_W-1:0]       probe_addr,
  output logic                    probe_rom
);

  localparam int PW     = page_bits(ADDR_W, PAGE_W);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int SEL_W  = IOCTL_ADDR_W - PAGE_W;

  state_t            state, state_n;
  logic [SLOT_W-1:0] slot_q;
  logic              dl_q, done_pend;
  logic [SEL_W-1:0]  sel;
  logic              sel_ok;
  logic              capture, arm_fire, commit, drop;
  logic              dl_rise, dl_fall, done_want, done_fire;
  logic [SLOTS-1:0]  loaded_n;
  logic              overflow_n;

  assign rom_download = ioctl_download && (ioctl_index == ROM_INDEX);

  // Slot index is the full upper download address so that bytes beyond the
  // last slot are detected instead of aliasing onto a low slot.
  assign sel    = ioctl_addr[IOCTL_ADDR_W-1:PAGE_W];
  assign sel_ok = (sel < SEL_W'(SLOTS));

  assign dl_rise   = rom_download & ~dl_q;
  assign dl_fall   = dl_q & ~rom_download;
  // done is held back until the FSM is idle, so a write still in flight
  // when the download ends completes before done is reported.
  assign done_want = done_pend | dl_fall;
  assign done_fire = done_want && (state == ST_IDLE);

  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    arm_fire = 1'b0;
    commit   = 1'b0;
    drop     = 1'b0;
    case (state)
      ST_IDLE: begin
        // ce_ref is ignored here, so a strobe coinciding with capture
        // never counts as the ARM strobe.
        if (ioctl_wr && rom_download) begin
          if (sel_ok) begin
            capture = 1'b1;
            state_n = ST_ARM;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_ARM: begin
        drop = ioctl_wr;
        if (ce_ref) begin
          arm_fire = 1'b1;
          state_n  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        drop = ioctl_wr;
        if (ce_ref) begin
          commit  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A new download clears status first; events of the same cycle then apply.
  always_comb begin
    loaded_n   = dl_rise ? '0 : loaded;
    overflow_n = (dl_rise ? 1'b0 : overflow) | drop;
    if (commit) loaded_n[slot_q] = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ioctl_wait <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      slot_q     <= '0;
      loaded     <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      done_pend  <= 1'b0;
      dl_q       <= 1'b0;
    end else begin
      dl_q      <= rom_download;
      loaded    <= loaded_n;
      overflow  <= overflow_n;
      done      <= done_fire;
      done_pend <= done_want & ~done_fire;
      // Address/data only change on capture, so they hold through ram_we.
      if (capture) begin
        ram_din    <= ioctl_dout;
        ram_addr   <= {PAGE_MAP[sel[SLOT_W-1:0]*PW +: PW], ioctl_addr[PAGE_W-1:0]};
        slot_q     <= sel[SLOT_W-1:0];
        ioctl_wait <= 1'b1;
      end
      if (arm_fire) ram_we <= 1'b1;
      if (commit) begin
        ram_we     <= 1'b0;
        ioctl_wait <= 1'b0;
      end
    end
  end

  logic unused_probe;
  assign unused_probe = ^probe_addr[PAGE_W-1:0];

  rom_page_match #(
    .SLOTS (SLOTS),
    .PW    (PW)
  ) u_page_match (
    .loaded     (loaded),
    .page_map   (PAGE_MAP),
    .probe_page (probe_addr[ADDR_W-1:PAGE_W]),
    .hit        (probe_rom)
  );

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader. A transaction-level model holds the queue
// of SDRAM writes the stream must produce, the expected loaded/overflow
// status and the probe rule; a per-cycle monitor checks the write port and
// rom_download against it, and literal checks pin the model.
// The page map places 0x107 on slot 0 and 0x100 on slot 1, and maps slots 2
// and 3 both onto page 0x000 to exercise the duplicate-page case.
module tb_rom_loader;

  localparam int PER = 16;
  localparam logic [35:0] MAP = {9'h000, 9'h000, 9'h100, 9'h107};

  typedef struct packed {
    logic [22:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        ce_ref = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [22:0] probe_addr = '0;
  logic        ioctl_wait, ram_we, rom_download, done, overflow, probe_rom;
  logic [22:0] ram_addr;
  logic [7:0]  ram_din;
  logic [3:0]  loaded;

  int   n_vec = 0, n_err = 0;
  wr_t  exp_q[$];
  logic [3:0] m_loaded = 4'b0;
  logic m_ovf = 1'b0;
  logic pend = 1'b0;
  logic [1:0] pend_slot = 2'd0;
  int   done_cnt = 0, we_len = 0;
  int   clks, nce;

  rom_loader #(.PAGE_MAP(MAP)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .rom_download(rom_download), .loaded(loaded),
    .done(done), .overflow(overflow), .probe_addr(probe_addr),
    .probe_rom(probe_rom)
  );

  always #5 clk_sys = ~clk_sys;

  // ce_ref: one-cycle strobe every PER clocks, changed 1 time unit after the edge.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_sys); #1;
      ce_ref = (cnt == PER-1);
      cnt = (cnt + 1) % PER;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] map_addr(input logic [24:0] a);
    logic [35:0] m;
    int s;
    m = MAP;
    s = int'(a[24:14]);
    return {m[s*9 +: 9], a[13:0]};
  endfunction

  function automatic logic model_probe(input logic [22:0] p);
    logic [35:0] m;
    m = MAP;
    for (int i = 0; i < 4; i++)
      if (m_loaded[i] && m[i*9 +: 9] == p[22:14]) return 1'b1;
    return 1'b0;
  endfunction

  // Per-cycle monitor: write port against the expected write queue.
  always @(negedge clk_sys) begin
    if (reset) begin
      we_len = 0;
    end else begin
      chk("rom_download", 32'(rom_download), 32'(ioctl_download && ioctl_index == 8'd0));
      if (done) done_cnt++;
      if (ram_we) begin
        we_len++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_we: ram_we=1 addr %0h, no write required", ram_addr);
        end else begin
          chk("ram_addr", 32'(ram_addr), 32'(exp_q[0].a));
          chk("ram_din", 32'(ram_din), 32'(exp_q[0].d));
        end
      end else if (we_len != 0) begin
        chk("we_len", 32'(we_len), 32'(PER));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        we_len = 0;
      end
    end
  end

  // All drive tasks start and end at posedge + 2.
  task automatic align_ce(input logic want);
    for (int g = 0; g < 2*PER; g++) begin
      if (ce_ref == want) break;
      @(posedge clk_sys); #2;
    end
  endtask

  task automatic pulse_wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    if (rom_download && a[24:14] < 11'd4) begin
      exp_q.push_back(wr_t'{map_addr(a), d});
      pend = 1'b1; pend_slot = a[15:14];
    end else if (rom_download) begin
      m_ovf = 1'b1;
    end
    @(posedge clk_sys); #2;
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(output int c, output int n);
    logic rel;
    c = 0; n = 0; rel = 1'b0;
    for (int g = 0; g < 8*PER; g++) begin
      @(negedge clk_sys);
      if (!ioctl_wait) begin rel = 1'b1; break; end
      @(posedge clk_sys);
      c++;
      if (ce_ref) n++;
    end
    if (!rel) begin
      n_vec++; n_err++;
      $display("FAIL wait_timeout: ioctl_wait still 1 after %0d clk, required 0", c);
    end
    if (pend) begin m_loaded[pend_slot] = 1'b1; pend = 1'b0; end
    @(posedge clk_sys); #2;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d, input logic align,
                      output int c, output int n);
    align_ce(align);
    pulse_wr(a, d);
    wait_idle(c, n);
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    if (idx == 8'd0) begin m_loaded = 4'b0; m_ovf = 1'b0; end
    repeat (2) @(posedge clk_sys);
    #2;
  endtask

  task automatic dl_end_done(input string tag, input int want);
    done_cnt = 0;
    ioctl_download = 1'b0;
    repeat (6) @(posedge clk_sys);
    #2;
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(want));
  endtask

  task automatic chk_status(input string tag);
    @(negedge clk_sys);
    chk({tag, "_loaded"}, 32'(loaded), 32'(m_loaded));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    @(posedge clk_sys); #2;
  endtask

  task automatic probe(input logic [22:0] p);
    probe_addr = p;
    @(negedge clk_sys);
    chk($sformatf("probe_%06h", p), 32'(probe_rom), 32'(model_probe(p)));
    @(posedge clk_sys); #2;
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clk_sys);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk_sys); #2 reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #2;

    // Single byte to slot 1 (page 0x100).
    dl_start(8'd0);
    send(25'h04123, 8'hA5, 1'b0, clks, nce);
    chk("single_nce", 32'(nce), 32'd2);
    chk("single_addr", 32'(ram_addr), 32'h400123);
    chk("single_din", 32'(ram_din), 32'hA5);
    chk("single_loaded", 32'(loaded), 32'b0010);
    chk_status("single");

    // Capture coincides with ce_ref: that strobe counts for nothing.
    send(25'h0C077, 8'h3C, 1'b1, clks, nce);
    chk("coinc_clks", 32'(clks), 32'(2*PER));
    chk("coinc_nce", 32'(nce), 32'd2);
    chk("coinc_loaded", 32'(loaded), 32'b1010);

    // Slot 4 is out of range: dropped, no wait, sticky overflow.
    send(25'h10000, 8'h5A, 1'b0, clks, nce);
    chk("oor_clks", 32'(clks), 32'd0);
    chk("oor_ovf", 32'(overflow), 32'd1);
    chk("oor_loaded", 32'(loaded), 32'b1010);
    chk_status("oor");
    dl_end_done("dl1", 1);

    // New download clears status; a write while busy is dropped.
    dl_start(8'd0);
    chk("rise_loaded", 32'(loaded), 32'd0);
    chk("rise_ovf", 32'(overflow), 32'd0);
    align_ce(1'b0);
    pulse_wr(25'h08010, 8'h11);
    repeat (3) @(posedge clk_sys);
    #2;
    ioctl_addr = 25'h08011; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
    m_ovf = 1'b1;
    @(posedge clk_sys); #2 ioctl_wr = 1'b0;
    wait_idle(clks, nce);
    chk("busy_ovf", 32'(overflow), 32'd1);
    chk("busy_din", 32'(ram_din), 32'h11);
    chk("busy_loaded", 32'(loaded), 32'b0100);
    chk_status("busy");
    dl_end_done("dl2", 1);

    // Abbreviated stream over slots 0-2: first, middle and last byte.
    dl_start(8'd0);
    for (int s = 0; s < 3; s++) begin
      send(25'(s << 14), 8'(s*16 + 1), 1'b0, clks, nce);
      send(25'((s << 14) | 14'h1FFF), 8'(s*16 + 2), 1'b0, clks, nce);
      send(25'((s << 14) | 14'h3FFF), 8'(s*16 + 3), 1'b0, clks, nce);
    end
    dl_end_done("stream", 1);
    chk("stream_loaded", 32'(loaded), 32'b0111);
    probe_addr = 23'h41C000;
    @(negedge clk_sys) chk("probe_41C000_lit", 32'(probe_rom), 32'd1);
    probe_addr = 23'h004000;
    @(negedge clk_sys) chk("probe_004000_lit", 32'(probe_rom), 32'd0);
    @(posedge clk_sys); #2;
    probe(23'h400000);
    probe(23'h000000);
    probe(23'h5FFFFF);
    probe(23'h43FFFF);
    chk_status("stream");

    // Slots 2 and 3 share page 0: later write wins, either slot hits.
    dl_start(8'd0);
    send(25'h0C005, 8'h77, 1'b0, clks, nce);
    chk("dup3_loaded", 32'(loaded), 32'b1000);
    probe_addr = 23'h000005;
    @(negedge clk_sys) chk("dup3_probe", 32'(probe_rom), 32'd1);
    @(posedge clk_sys); #2;
    send(25'h08005, 8'h88, 1'b0, clks, nce);
    chk("dup_addr", 32'(ram_addr), 32'h000005);
    chk("dup_din", 32'(ram_din), 32'h88);
    probe(23'h000005);
    chk_status("dup");
    dl_end_done("dup", 1);

    // Download ends while the write is still in ARM.
    dl_start(8'd0);
    align_ce(1'b0);
    done_cnt = 0;
    pulse_wr(25'h04001, 8'h99);
    ioctl_download = 1'b0;
    wait_idle(clks, nce);
    chk("late_nce", 32'(nce), 32'd2);
    chk("late_done_early", 32'(done_cnt), 32'd0);
    repeat (5) @(posedge clk_sys);
    #2;
    chk("late_done_cnt", 32'(done_cnt), 32'd1);
    chk("late_loaded", 32'(loaded), 32'b0010);

    // Reset between ce_ref pulses in WRITE aborts the write.
    dl_start(8'd0);
    align_ce(1'b0);
    pulse_wr(25'h04002, 8'h5C);
    for (int g = 0; g < 4*PER; g++) begin
      @(negedge clk_sys);
      if (ram_we) break;
    end
    repeat (2) @(posedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk("rstw_we", 32'(ram_we), 32'd0);
    chk("rstw_wait", 32'(ioctl_wait), 32'd0);
    exp_q.delete(); pend = 1'b0; m_loaded = 4'b0; m_ovf = 1'b0;
    @(negedge clk_sys);
    chk("rstw_loaded", 32'(loaded), 32'd0);
    @(posedge clk_sys); #2 reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #2;
    send(25'h08123, 8'hE1, 1'b0, clks, nce);
    chk("rstw_nce", 32'(nce), 32'd2);
    chk("rstw_addr", 32'(ram_addr), 32'h000123);
    chk("rstw_loaded2", 32'(loaded), 32'b0100);
    dl_end_done("rstw", 1);

    // Wrong index: not a ROM download, nothing happens.
    dl_start(8'd1);
    for (int i = 0; i < 3; i++) begin
      pulse_wr(25'(25'h04000 + i), 8'(i));
      @(negedge clk_sys);
      chk("wrong_wait", 32'(ioctl_wait), 32'd0);
      @(posedge clk_sys); #2;
    end
    dl_end_done("wrong", 0);
    chk_status("wrong");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1);
  end

endmodule
